// File: rtl/delapan_bit_gabung_coba_if.sv
// Operand/product bundle for the sequential 8x8 shift-and-add multiplier.
// The master drives operands and the start request; the slave returns the product.
interface delapan_bit_gabung_coba_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        enable;
  logic [15:0] q;
  logic        cout;
  logic        done_delapanbitgabungcoba;

  modport master (
    output a, b, enable,
    input  q, cout, done_delapanbitgabungcoba
  );

  modport slave (
    input  a, b, enable,
    output q, cout, done_delapanbitgabungcoba
  );
endinterface

// File: rtl/delapan_bit_gabung_coba.sv
// Sequential 8x8 unsigned shift-and-add multiplier: one load cycle, eight
// add/shift iterations, then the 16-bit product is held with a done level.
module delapan_bit_gabung_coba (
  input  logic                      clock,
  input  logic                      reset,
  delapan_bit_gabung_coba_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'd7;

  // Declaration values match the reset values so the block works without reset.
  state_t      r_state = S_IDLE;
  logic [7:0]  r_m     = 8'd0;
  logic [7:0]  r_a     = 8'd0;
  logic [7:0]  r_qr    = 8'd0;
  logic        r_c     = 1'b0;
  logic [3:0]  r_cnt   = 4'd0;
  logic [15:0] r_q     = 16'd0;

  state_t      w_state_nxt;
  logic [7:0]  w_addend;
  logic [8:0]  w_sum;
  logic [7:0]  w_a_nxt;
  logic [7:0]  w_q_nxt;

  // One iteration: conditional 9-bit add, then shift {C,A,Q} right by one.
  assign w_addend = r_qr[0] ? r_m : 8'd0;
  assign w_sum    = {1'b0, r_a} + {1'b0, w_addend};
  assign w_a_nxt  = w_sum[8:1];
  assign w_q_nxt  = {w_sum[0], r_qr[7:1]};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.enable)         w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_ITER) w_state_nxt = S_DONE;
      S_DONE:  if (!bus.enable)        w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_m   <= 8'd0;
      r_a   <= 8'd0;
      r_qr  <= 8'd0;
      r_c   <= 1'b0;
      r_cnt <= 4'd0;
      r_q   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.enable) begin
            r_m   <= bus.a;
            r_qr  <= bus.b;
            r_a   <= 8'd0;
            r_c   <= 1'b0;
            r_cnt <= 4'd0;
          end
        end
        S_BUSY: begin
          // The adder carry is shifted into A[7]; C is cleared by the shift.
          r_a   <= w_a_nxt;
          r_qr  <= w_q_nxt;
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LAST_ITER) r_q <= {w_a_nxt, w_q_nxt};
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.q                         = r_q;
  assign bus.cout                      = r_c;
  assign bus.done_delapanbitgabungcoba = (r_state == S_DONE);

endmodule

// File: tb/tb_delapan_bit_gabung_coba.sv
// Directed bench for the sequential multiplier: latency, operand capture,
// done handshake, async reset mid-computation, and back-to-back restart.
module tb_delapan_bit_gabung_coba;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  delapan_bit_gabung_coba_if bus ();

  delapan_bit_gabung_coba dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the DUT in IDLE; enable is raised and left high.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    bus.a      = a;
    bus.b      = b;
    bus.enable = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);
    check({tag, "_done_e8"}, 16'(bus.done_delapanbitgabungcoba), 16'd0);
    @(posedge clock);
    @(negedge clock);
    check({tag, "_q"},    bus.q, exp);
    check({tag, "_done"}, 16'(bus.done_delapanbitgabungcoba), 16'd1);
    check({tag, "_cout"}, 16'(bus.cout), 16'd0);
  endtask

  task automatic leave_done();
    bus.enable = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("leave_done", 16'(bus.done_delapanbitgabungcoba), 16'd0);
  endtask

  initial begin
    // Never reset: power-up values alone must give a correct first product.
    bus.a      = 8'hDB;
    bus.b      = 8'hAA;
    bus.enable = 1'b1;
    repeat (8) @(posedge clock);
    @(negedge clock);                                  // t=80
    check("first_done_e8", 16'(bus.done_delapanbitgabungcoba), 16'd0);
    @(negedge clock);                                  // t=90
    @(negedge clock);                                  // t=100
    check("first_q",    bus.q, 16'h916E);
    check("first_cout", 16'(bus.cout), 16'd0);
    check("first_done", 16'(bus.done_delapanbitgabungcoba), 16'd1);

    // enable held in DONE: no restart, result stable.
    bus.a = 8'h01;
    bus.b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("hold_q",    bus.q, 16'h916E);
      check("hold_done", 16'(bus.done_delapanbitgabungcoba), 16'd1);
    end

    // One cycle low, then restart; q keeps the old product meanwhile.
    leave_done();
    check("idle_q_kept", bus.q, 16'h916E);
    run_op("b2b", 8'h12, 8'h34, 16'h03A8);

    leave_done();
    run_op("ffff", 8'hFF, 8'hFF, 16'hFE01);
    leave_done();
    run_op("zero_a", 8'h00, 8'h5A, 16'h0000);
    leave_done();
    run_op("max_then", 8'hFF, 8'h80, 16'h7F80);
    leave_done();
    run_op("zero_b", 8'h37, 8'h00, 16'h0000);
    leave_done();

    // Operands changed on edge 3 must not affect the result.
    bus.a      = 8'h0F;
    bus.b      = 8'h10;
    bus.enable = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    bus.a = 8'h01;
    bus.b = 8'h01;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("capture_q",    bus.q, 16'h00F0);
    check("capture_done", 16'(bus.done_delapanbitgabungcoba), 16'd1);
    leave_done();

    // Async reset spanning BUSY edge 5.
    bus.a      = 8'hFF;
    bus.b      = 8'hFF;
    bus.enable = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    #3;
    reset = 1'b1;
    bus.a = 8'h0D;
    bus.b = 8'h0B;
    #1;
    check("rst_q",    bus.q, 16'h0000);
    check("rst_done", 16'(bus.done_delapanbitgabungcoba), 16'd0);
    check("rst_cout", 16'(bus.cout), 16'd0);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_q", bus.q, 16'h0000);
    run_op("after_rst", 8'h0D, 8'h0B, 16'h008F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
